// File: rtl/spi_shift_engine.sv
// Byte-wide SPI mode-0 master shift engine: full duplex, MSB first, four selectable SCLK rates.
// A transfer runs for 16 SCLK half-periods and busy is high for the whole transfer.
module spi_shift_engine #(
  parameter int unsigned HALF0 = 1,
  parameter int unsigned HALF1 = 2,
  parameter int unsigned HALF2 = 4,
  parameter int unsigned HALF3 = 64
) (
  input  logic       clk7,
  input  logic       rst,
  input  logic       start_write,
  input  logic       start_read,
  input  logic [7:0] data_in,
  input  logic [1:0] speed,
  input  logic       miso,
  output logic       mosi,
  output logic       sclk,
  output logic       busy,
  output logic [7:0] data_out
);

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(15);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  state_t            state_next;
  logic [DIV_W-1:0]  half_sel;
  logic [DIV_W-1:0]  hlat;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  cnt;
  logic [BYTE_W-1:0] tx;
  logic [BYTE_W-1:0] rx;
  logic              start;
  logic              load;
  logic              tick;
  logic              rise;
  logic              fall;
  logic              done;

  assign start = start_write | start_read;

  // Reload value for the divider: half-period minus one.
  always_comb begin
    half_sel = DIV_W'(HALF0 - 1);
    case (speed)
      2'd0:    half_sel = DIV_W'(HALF0 - 1);
      2'd1:    half_sel = DIV_W'(HALF1 - 1);
      2'd2:    half_sel = DIV_W'(HALF2 - 1);
      default: half_sel = DIV_W'(HALF3 - 1);
    endcase
  end

  always_ff @(posedge clk7 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-cycle control strobes decoded from state, divider and edge count.
  always_comb begin
    load = 1'b0;
    tick = 1'b0;
    rise = 1'b0;
    fall = 1'b0;
    done = 1'b0;
    if (state == IDLE) begin
      load = start;
    end else begin
      tick = (div == '0);
      rise = tick & ~cnt[0];
      done = tick & (cnt == LAST_EDGE);
      fall = tick & cnt[0] & (cnt != LAST_EDGE);
    end
  end

  // tx refills with ones as it shifts and is reset to all-ones on completion, so mosi idles high.
  always_ff @(posedge clk7 or posedge rst) begin
    if (rst) begin
      tx       <= '1;
      rx       <= '0;
      hlat     <= '0;
      div      <= '0;
      cnt      <= '0;
      sclk     <= 1'b0;
      busy     <= 1'b0;
      data_out <= '0;
    end else begin
      busy <= (state_next == SHIFT);
      if (load) begin
        tx   <= start_write ? data_in : 8'hFF;
        hlat <= half_sel;
        div  <= half_sel;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        if (!tick) begin
          div <= div - DIV_W'(1);
        end else begin
          div  <= hlat;
          cnt  <= cnt + CNT_W'(1);
          sclk <= ~sclk;
        end
        if (rise) rx <= {rx[6:0], miso};
        if (fall) tx <= {tx[6:0], 1'b1};
        if (done) begin
          sclk     <= 1'b0;
          data_out <= rx;
          tx       <= '1;
        end
      end
    end
  end

  assign mosi = tx[7];

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: table of transfers with a MISO slave model,
// plus hand-written back-to-back and mid-transfer reset sequences.
module tb_spi_shift_engine;

  logic       clk7 = 1'b0;
  logic       rst;
  logic       start_write;
  logic       start_read;
  logic [7:0] data_in;
  logic [1:0] speed;
  logic       miso;
  logic       mosi;
  logic       sclk;
  logic       busy;
  logic [7:0] data_out;

  int checks   = 0;
  int failures = 0;

  spi_shift_engine dut (
    .clk7        (clk7),
    .rst         (rst),
    .start_write (start_write),
    .start_read  (start_read),
    .data_in     (data_in),
    .speed       (speed),
    .miso        (miso),
    .mosi        (mosi),
    .sclk        (sclk),
    .busy        (busy),
    .data_out    (data_out)
  );

  always #5 clk7 = ~clk7;

  typedef struct {
    logic       sw;
    logic       sr;
    logic [7:0] din;
    logic [1:0] spd;
    logic [1:0] spd_mid;
    logic [7:0] mb;
    int         mid_at;
    logic [7:0] exp_mosi;
    int         exp_cyc;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[5];

  int         ncyc;
  int         nrise;
  logic [7:0] mosi_bits;
  logic       mosi_first;
  bit         width_ok;
  bit         hold_ok;

  function automatic int half_of(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 64;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a transfer at a negedge and follows it to the first negedge with busy low.
  task automatic do_xfer(input vec_t v);
    logic [7:0] hold_val;
    logic       prev;
    int         run_len;
    int         bi;
    int         h;
    h          = half_of(v.spd);
    hold_val   = data_out;
    bi         = 7;
    miso       = v.mb[bi];
    start_write = v.sw;
    start_read  = v.sr;
    data_in     = v.din;
    speed       = v.spd;
    @(negedge clk7);
    start_write = 1'b0;
    start_read  = 1'b0;
    ncyc       = 0;
    nrise      = 0;
    mosi_bits  = 8'h00;
    mosi_first = mosi;
    width_ok   = 1'b1;
    hold_ok    = 1'b1;
    prev       = 1'b0;
    run_len    = 0;
    while (busy && ncyc < 3000) begin
      start_write = 1'b0;
      start_read  = 1'b0;
      ncyc++;
      if (data_out !== hold_val) hold_ok = 1'b0;
      if (sclk !== prev) begin
        if (run_len != h) width_ok = 1'b0;
        run_len = 1;
        if (sclk) begin
          nrise++;
          mosi_bits = {mosi_bits[6:0], mosi};
        end else if (bi > 0) begin
          bi--;
          miso = v.mb[bi];
        end
      end else begin
        run_len++;
      end
      prev = sclk;
      if (ncyc == 3) speed = v.spd_mid;
      if (ncyc == v.mid_at) begin
        start_write = 1'b1;
        start_read  = 1'b1;
        data_in     = ~v.din;
      end
      @(negedge clk7);
    end
    start_write = 1'b0;
    start_read  = 1'b0;
    if (prev && run_len != h) width_ok = 1'b0;
  endtask

  task automatic run_check(input vec_t v, input string tag);
    do_xfer(v);
    chk({tag, "_busy_cycles"}, 32'(ncyc), 32'(v.exp_cyc));
    chk({tag, "_mosi_bits"}, 32'(mosi_bits), 32'(v.exp_mosi));
    chk({tag, "_mosi_first"}, 32'(mosi_first), 32'(v.exp_mosi[7]));
    chk({tag, "_sclk_pulses"}, 32'(nrise), 32'd8);
    chk({tag, "_sclk_widths"}, 32'(width_ok), 32'd1);
    chk({tag, "_dout_held"}, 32'(hold_ok), 32'd1);
    chk({tag, "_data_out"}, 32'(data_out), 32'(v.exp_dout));
    chk({tag, "_sclk_idle"}, 32'(sclk), 32'd0);
    chk({tag, "_mosi_idle"}, 32'(mosi), 32'd1);
  endtask

  initial begin
    vec_t b2b0;
    vec_t b2b1;
    vec_t rv;
    int   guard;
    int   rises;
    logic psclk;

    vecs[0] = '{1'b1, 1'b0, 8'hA5, 2'd0, 2'd3, 8'h5A, 0,  8'hA5, 16,   8'h5A};
    vecs[1] = '{1'b0, 1'b1, 8'h12, 2'd3, 2'd0, 8'h3C, 0,  8'hFF, 1024, 8'h3C};
    vecs[2] = '{1'b1, 1'b0, 8'h81, 2'd1, 2'd2, 8'h7E, 0,  8'h81, 32,   8'h7E};
    vecs[3] = '{1'b1, 1'b1, 8'h00, 2'd2, 2'd1, 8'hC3, 20, 8'h00, 64,   8'hC3};
    vecs[4] = '{1'b1, 1'b0, 8'h0F, 2'd0, 2'd2, 8'hF0, 7,  8'h0F, 16,   8'hF0};
    b2b0    = '{1'b1, 1'b0, 8'h6B, 2'd0, 2'd2, 8'h99, 0,  8'h6B, 16,   8'h99};
    b2b1    = '{1'b0, 1'b1, 8'h00, 2'd2, 2'd0, 8'h24, 0,  8'hFF, 64,   8'h24};
    rv      = '{1'b1, 1'b0, 8'hA5, 2'd1, 2'd1, 8'hE1, 0,  8'hA5, 32,   8'hE1};

    rst = 1'b1;
    start_write = 1'b0;
    start_read  = 1'b0;
    data_in     = 8'h00;
    speed       = 2'd0;
    miso        = 1'b0;
    @(negedge clk7);
    @(negedge clk7);
    chk("reset_sclk", 32'(sclk), 32'd0);
    chk("reset_mosi", 32'(mosi), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'h00);
    rst = 1'b0;
    @(negedge clk7);

    for (int i = 0; i < 5; i++) begin
      run_check(vecs[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clk7);
    end

    // Back-to-back: second start lands on the first edge with busy low.
    run_check(b2b0, "b2b_first");
    run_check(b2b1, "b2b_second");
    repeat (2) @(negedge clk7);

    // Reset during the 5th SCLK high phase aborts immediately.
    start_write = 1'b1;
    data_in     = 8'hA5;
    speed       = 2'd1;
    miso        = 1'b1;
    @(negedge clk7);
    start_write = 1'b0;
    rises = 0;
    guard = 0;
    psclk = 1'b0;
    while (rises < 5 && guard < 200) begin
      if (sclk && !psclk) rises++;
      psclk = sclk;
      guard++;
      if (rises < 5) @(negedge clk7);
    end
    chk("rst_reached_5th_high", 32'(rises), 32'd5);
    chk("rst_pre_sclk_high", 32'(sclk), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_abort_sclk", 32'(sclk), 32'd0);
    chk("rst_abort_mosi", 32'(mosi), 32'd1);
    chk("rst_abort_busy", 32'(busy), 32'd0);
    chk("rst_abort_data_out", 32'(data_out), 32'h00);
    @(negedge clk7);
    rst = 1'b0;
    @(negedge clk7);
    chk("rst_release_busy", 32'(busy), 32'd0);
    chk("rst_release_data_out", 32'(data_out), 32'h00);
    run_check(rv, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Byte-wide SPI mode-0 master shift engine, directly downstream of the bus-side SPI controller.
- Consumes the controller's start_write/start_read strobes, write data and speed select. Produces SCLK/MOSI, captures MISO and returns the received byte plus a busy flag.
- Full duplex: every transfer shifts out 8 bits and shifts in 8 bits, MSB first.

Parameters:
- HALF0, 1, SCLK half-period in clk7 cycles for speed=00 (≈3.5 MHz)
- HALF1, 2, half-period for speed=01 (≈1.77 MHz)
- HALF2, 4, half-period for speed=10 (≈887 kHz)
- HALF3, 64, half-period for speed=11 (≈55 kHz, SD card init rate)
- Legal range for all HALFn: 1..256 (8-bit divider).

Ports:
- clk7  in  1  7 MHz system clock; all flops on rising edge
- rst  in  1  asynchronous, active-high reset
- start_write  in  1  one-cycle strobe: transmit data_in
- start_read  in  1  one-cycle strobe: transmit 8'hFF, receive
- data_in  in  8  byte to transmit on start_write
- speed  in  2  half-period select, sampled at start
- miso  in  1  SPI MISO
- mosi  out  1  SPI MOSI
- sclk  out  1  SPI SCLK, idle low (CPOL=0)
- busy  out  1  high while a transfer is in progress
- data_out  out  8  last received byte

Behaviour:
- Clocking and reset: one clock, clk7. Reset is asynchronous, active-high on rst.
- Reset values: sclk=0, mosi=1, busy=0, data_out=8'h00. Tx and rx shift registers are cleared to 8'hFF and 8'h00. Divider and edge counter are cleared.
- States: IDLE and SHIFT. The state is observable as busy.
- IDLE, on a clock edge with start_write=1:
  - tx <= data_in
  - hlat <= HALF[speed]−1 (speed is latched for the whole transfer)
  - div <= hlat value
  - edge count <= 0
  - busy <= 1; go to SHIFT
- IDLE, start_read=1: same as start_write, but tx <= 8'hFF.
- Both strobes high together: write wins, and tx <= data_in.
- Strobes arriving while busy=1 are ignored. The transfer in progress is unaffected.
- mosi = tx[7] whenever busy=1. mosi=1 in IDLE. The first bit is valid on the cycle busy rises, i.e. one full half-period before the first rising SCLK edge.
- SHIFT, divider:
  - If div≠0, decrement div.
  - If div=0, reload div <= hlat, toggle sclk and increment the edge count (0..15).
- Rising toggle (sclk 0→1, even edge count): rx <= {rx[6:0], miso}. miso is sampled on the same clk7 edge that raises sclk.
- Falling toggle (sclk 1→0, odd edge count below 15): tx <= {tx[6:0], 1'b1}.
- 16th toggle (falling, edge count 15):
  - sclk <= 0
  - data_out <= {rx[6:0] at that edge} final value. This is all 8 sampled bits; rx already holds the 8th bit, captured at the preceding rising toggle.
  - busy <= 0; return to IDLE.
- Timing contract: busy is high for exactly 16×HALF[speed] clk7 cycles. A new start is accepted on the first edge where busy=0, giving back-to-back transfers with no dead cycle.
- data_out stability: data_out changes only at transfer completion, never mid-transfer. The controller may latch it on the same edge that starts the next read.
- A speed change during a transfer has no effect until the next start.
- A miso change between SCLK edges has no effect. Only the value at a rising toggle is captured.
- rst mid-transfer: immediate abort to the reset values. No partial byte reaches data_out, and sclk returns low without a completing edge.

Test Plan:
- Reset, then start_write with data_in=8'hA5 and speed=00 (HALF=1) → busy high for exactly 16 cycles. MOSI presents 1,0,1,0,0,1,0,1 at successive rising SCLK edges. 8 SCLK pulses, each 1 cycle high and 1 cycle low. busy falls and sclk=0 together.
- start_read, speed=11, slave model drives miso=8'h3C MSB-first (changes after each falling SCLK) → MOSI constant 1, busy high for 1024 cycles, data_out=8'h3C only after busy falls. data_out holds its previous value throughout.
- Full duplex: start_write 8'h81 while miso returns 8'h7E, speed=01 → data_out=8'h7E, busy high for 32 cycles.
- Start_write and start_read asserted together with data_in=8'h00 → MOSI stays 0 for all 8 bits (write priority). A second strobe mid-transfer is ignored and the bit sequence is unchanged.
- Back-to-back: a new start_read on the first cycle busy=0, and speed changed to 10 mid-first-transfer → the second transfer begins immediately. The first runs at the old rate and the second at HALF=4 (64 cycles).
- Assert rst during the 5th SCLK high phase → sclk=0, mosi=1, busy=0, data_out=8'h00 immediately. After release, the next start_write completes normally.
